booth_mult_seq: RTL and testbench

BOOTH_MULT_SEQ -- requirements
Module: booth_mult_seq

---
 rtl/booth_mult_seq.sv | 106 ++++++++++
 tb/tb_booth_mult_seq.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/booth_mult_seq.sv
// Sequential radix-2 Booth multiplier for signed two's-complement operands.
// One Booth step per clock; an N-bit multiply takes N RUN cycles plus one
// DONE cycle. The product is the low 2N bits of {A,Q} and holds in IDLE.
module booth_mult_seq #(
    parameter int N = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [N-1:0]     multiplicand,
    input  logic [N-1:0]     multiplier,
    output logic             ready,
    output logic             busy,
    output logic             done,
    output logic [2*N-1:0]   product
);

    localparam int CW = $clog2(N + 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t state, state_nxt;

    // Accumulator and multiplicand carry one extra bit so -2^(N-1) never overflows.
    logic [N:0]    acc;
    logic [N:0]    mcand;
    logic [N:0]    sum;
    logic [N-1:0]  q;
    logic          q_m1;
    logic [CW-1:0] cnt;

    // State register with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Next-state and status outputs, decoded from the current state.
    always_comb begin
        state_nxt = state;
        ready     = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        unique case (state)
            IDLE: begin
                ready = 1'b1;
                if (start) state_nxt = RUN;
            end
            RUN: begin
                busy = 1'b1;
                if (cnt == CW'(1)) state_nxt = DONE;
            end
            DONE: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Booth add/subtract selected by the pair {Q[0], Q_-1}.
    always_comb begin
        unique case ({q[0], q_m1})
            2'b01:   sum = acc + mcand;
            2'b10:   sum = acc - mcand;
            default: sum = acc;
        endcase
    end

    // Operand capture in IDLE, then add/sub followed by arithmetic right shift of {A,Q,Q_-1}.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc   <= '0;
            mcand <= '0;
            q     <= '0;
            q_m1  <= 1'b0;
            cnt   <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (start) begin
                        mcand <= {multiplicand[N-1], multiplicand};
                        q     <= multiplier;
                        acc   <= '0;
                        q_m1  <= 1'b0;
                        cnt   <= CW'(N);
                    end
                end
                RUN: begin
                    acc  <= {sum[N], sum[N:1]};
                    q    <= {sum[0], q[N-1:1]};
                    q_m1 <= q[0];
                    cnt  <= cnt - CW'(1);
                end
                default: ;
            endcase
        end
    end

    assign product = {acc[N-1:0], q};

endmodule

// File: tb/tb_booth_mult_seq.sv
// Testbench for booth_mult_seq (N=4): a timeline model of the handshake plus
// a signed reference multiply, checked every cycle, with literal expectations.
module tb_booth_mult_seq;

    localparam int N = 4;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic [N-1:0] multiplicand = '0;
    logic [N-1:0] multiplier = '0;
    logic         ready, busy, done;
    logic [2*N-1:0] product;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int done_count = 0;
    bit armed = 1'b0;

    // Model: cycles left in the current operation (0 = idle) and expected product.
    int           left = 0;
    logic [7:0]   exp_prod = '0;

    booth_mult_seq #(.N(N)) dut (
        .clk(clk),
        .rst(rst),
        .start(start),
        .multiplicand(multiplicand),
        .multiplier(multiplier),
        .ready(ready),
        .busy(busy),
        .done(done),
        .product(product)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] ref_mul(input logic [3:0] a, input logic [3:0] b);
        int x, y;
        x = $signed(a);
        y = $signed(b);
        return 8'(x * y);
    endfunction

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference timeline: accept -> N busy cycles -> one done cycle -> idle.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (rst) begin
            left     <= 0;
            exp_prod <= '0;
        end else if (left == 0) begin
            if (start) begin
                left     <= N + 1;
                exp_prod <= ref_mul(multiplicand, multiplier);
            end
        end else begin
            left <= left - 1;
        end
    end

    // Compare every cycle, away from the active edge.
    always @(negedge clk) begin
        if (armed) begin
            chk("ready", 16'(ready), 16'(left == 0));
            chk("busy",  16'(busy),  16'(left >= 2));
            chk("done",  16'(done),  16'(left == 1));
            if (left <= 1) chk("product", 16'(product), 16'(exp_prod));
        end
        if (done === 1'b1) done_count++;
    end

    // Launch one operation from idle; check done latency and the literal product.
    task automatic run_op(input logic [3:0] m, input logic [3:0] q,
                          input logic [7:0] lit, input string name, input bit lit_chk);
        multiplicand = m;
        multiplier   = q;
        start        = 1'b1;
        @(posedge clk); #1;
        start        = 1'b0;
        multiplicand = 4'($urandom);
        multiplier   = 4'($urandom);
        repeat (N) @(posedge clk);
        @(negedge clk);
        chk({name, "_done_latency"}, 16'(done), 16'd1);
        if (lit_chk) chk({name, "_product"}, 16'(product), 16'(lit));
        @(posedge clk); #1;
        chk({name, "_ready_after"}, 16'(ready), 16'd1);
    endtask

    task automatic wait_done(input string name, output int at_cyc);
        bit got = 1'b0;
        at_cyc = -1;
        for (int j = 0; j < 20 && !got; j++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                got    = 1'b1;
                at_cyc = cyc;
            end
        end
        chk({name, "_timeout"}, 16'(got), 16'd1);
    endtask

    initial begin
        int d0;
        int t_prev, t_now;
        logic [3:0] bm [3];
        logic [3:0] bq [3];
        logic [7:0] bp [3];

        // Reset state.
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        armed = 1'b1;
        chk("rst_ready", 16'(ready), 16'd1);
        chk("rst_busy", 16'(busy), 16'd0);
        chk("rst_done", 16'(done), 16'd0);
        chk("rst_product", 16'(product), 16'h00);
        @(posedge clk); #1;

        // Basic and corner-case products.
        run_op(4'd3, 4'hE, 8'hFA, "m3_qm2", 1'b1);
        run_op(4'h8, 4'h8, 8'h40, "m8_q8", 1'b1);
        run_op(4'h8, 4'h7, 8'hC8, "mm8_q7", 1'b1);
        run_op(4'h7, 4'h7, 8'h31, "m7_q7", 1'b1);
        repeat (2) @(posedge clk);
        #1;
        chk("hold_in_idle", 16'(product), 16'h31);

        // Start pulses and operand changes while running are ignored.
        d0 = done_count;
        multiplicand = 4'd5;
        multiplier   = 4'd3;
        start        = 1'b1;
        @(posedge clk); #1;
        multiplicand = 4'hF;
        multiplier   = 4'hF;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        chk("ignore_product", 16'(product), 16'h0F);
        chk("ignore_one_done", 16'(done_count - d0), 16'd1);

        // Reset on the second RUN cycle aborts without a done pulse.
        d0 = done_count;
        multiplicand = 4'd7;
        multiplier   = 4'd7;
        start        = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("abort_ready", 16'(ready), 16'd1);
        chk("abort_busy", 16'(busy), 16'd0);
        chk("abort_product", 16'(product), 16'h00);
        repeat (8) @(posedge clk);
        #1;
        chk("abort_no_done", 16'(done_count - d0), 16'd0);
        run_op(4'd2, 4'hD, 8'hFA, "m2_qm3", 1'b1);

        // Start held high: three back-to-back operations every N+2 cycles.
        bm[0] = 4'hD; bq[0] = 4'd5; bp[0] = 8'hF1;
        bm[1] = 4'd6; bq[1] = 4'hC; bp[1] = 8'hE8;
        bm[2] = 4'hF; bq[2] = 4'hF; bp[2] = 8'h01;
        multiplicand = bm[0];
        multiplier   = bq[0];
        start        = 1'b1;
        t_prev = 0;
        for (int i = 0; i < 3; i++) begin
            wait_done("b2b", t_now);
            chk("b2b_product", 16'(product), 16'(bp[i]));
            if (i > 0) chk("b2b_period", 16'(t_now - t_prev), 16'(N + 2));
            t_prev = t_now;
            if (i < 2) begin
                multiplicand = bm[i+1];
                multiplier   = bq[i+1];
            end else begin
                start = 1'b0;
            end
        end
        @(posedge clk); #1;

        // Exhaustive sweep; the per-cycle compare checks every product.
        for (int mi = 0; mi < 16; mi++) begin
            for (int qi = 0; qi < 16; qi++) begin
                run_op(4'(mi), 4'(qi), ref_mul(4'(mi), 4'(qi)), "sweep", 1'b0);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
